// File: rtl/pc_next_if.sv
// Request/response bundle between hazard/decode logic and the next-PC unit.
// The master side issues stall and redirect requests; the slave side returns the fetch PC.
interface pc_next_if #(
  parameter int unsigned WIDTH = 32
);
  logic             stall;
  logic             br_take;
  logic [WIDTH-1:0] br_target;
  logic             jr_take;
  logic [WIDTH-1:0] jr_target;
  logic             jmp_take;
  logic [WIDTH-1:0] jmp_target;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus1;
  logic             redirect;
  logic             pending;

  modport master (
    output stall, br_take, br_target, jr_take, jr_target, jmp_take, jmp_target,
    input  pc, pc_plus1, redirect, pending
  );

  modport slave (
    input  stall, br_take, br_target, jr_take, jr_target, jmp_take, jmp_target,
    output pc, pc_plus1, redirect, pending
  );
endinterface

// File: rtl/pc_next_unit.sv
// Next-PC generator: prioritised branch/jr/jmp select, stall hold, and a one-entry
// buffer that keeps a redirect raised during stall until fetch resumes.
module pc_next_unit #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input logic     clk,
  input logic     rst,
  pc_next_if.slave bus
);

  localparam logic [WIDTH-1:0] One = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
  logic             pend_v_q, pend_v_d;
  logic             redirect_q, redirect_d;
  logic             sel_take;
  logic [WIDTH-1:0] sel_target;

  // Older instruction (EX-stage branch) wins over ID-stage jumps.
  always_comb begin
    sel_take = bus.br_take | bus.jr_take | bus.jmp_take;
    if (bus.br_take) begin
      sel_target = bus.br_target;
    end else if (bus.jr_take) begin
      sel_target = bus.jr_target;
    end else begin
      sel_target = bus.jmp_target;
    end
  end

  always_comb begin
    pc_d       = pc_q;
    pend_v_d   = pend_v_q;
    pend_tgt_d = pend_tgt_q;
    redirect_d = 1'b0;
    if (!bus.stall) begin
      if (sel_take) begin
        pc_d       = sel_target;
        pend_v_d   = 1'b0;
        redirect_d = 1'b1;
      end else if (pend_v_q) begin
        pc_d       = pend_tgt_q;
        pend_v_d   = 1'b0;
        redirect_d = 1'b1;
      end else begin
        pc_d = pc_q + One;
      end
    end else if (sel_take) begin
      // A newer request during stall replaces any older buffered one.
      pend_v_d   = 1'b1;
      pend_tgt_d = sel_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      pend_v_q   <= 1'b0;
      pend_tgt_q <= '0;
      redirect_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pend_v_q   <= pend_v_d;
      pend_tgt_q <= pend_tgt_d;
      redirect_q <= redirect_d;
    end
  end

  assign bus.pc       = pc_q;
  assign bus.pc_plus1 = pc_q + One;
  assign bus.redirect = redirect_q;
  assign bus.pending  = pend_v_q;

endmodule

// File: doc/pc_next_unit.md
# pc_next_unit

Parametrised next-PC generator for the ZAFx32 fetch stage, replacing the fixed 2-input branch/PC+1 select. It holds the program counter register and picks the next PC from sequential increment, conditional branch, jump and jump-register targets using a fixed priority. It honours a pipeline stall, and a one-entry pending-redirect buffer keeps any redirect that arrives while fetch is stalled. The PC is word-addressed, so sequential fetch is PC+1.

## Interface
- WIDTH, 32, PC and target width in bits.
- RESET_PC, 0, PC value loaded on reset (WIDTH bits).

- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- stall  in  1  fetch hold request from hazard logic.
- br_take  in  1  branch resolved taken (EX stage).
- br_target  in  WIDTH  branch target.
- jr_take  in  1  jump-register resolved (ID stage).
- jr_target  in  WIDTH  register-sourced target.
- jmp_take  in  1  direct jump decoded (ID stage).
- jmp_target  in  WIDTH  jump target.
- pc  out  WIDTH  current fetch address (registered).
- pc_plus1  out  WIDTH  pc + 1 modulo 2^WIDTH (combinational from pc).
- redirect  out  1  registered; high for exactly the cycle in which pc holds a non-sequential value loaded in the previous cycle. Drives flush.
- pending  out  1  registered; pending-redirect buffer occupied.

## Operation
- Request priority, highest first: br_take > jr_take > jmp_take. The branch is in the older instruction, so it wins. sel_take = OR of the three take inputs. sel_target = target of the highest asserted take.
- State: pc (WIDTH), pend_v (1), pend_tgt (WIDTH), redirect (1).
- Reset (rst=1 at edge): pc=RESET_PC, pend_v=0, pend_tgt=0, redirect=0. rst overrides every other input, including any redirect in flight; a pending redirect is discarded.
- Update rules when stall=0:
  - If sel_take: pc<=sel_target, pend_v<=0, redirect<=1. A live request beats a pending one; the pending one is dropped.
  - Else if pend_v: pc<=pend_tgt, pend_v<=0, redirect<=1.
  - Else: pc<=pc+1 (wraps from 2^WIDTH-1 to 0), redirect<=0.
- Update rules when stall=1:
  - pc holds and redirect<=0.
  - If sel_take: pend_v<=1 and pend_tgt<=sel_target. A newer request overwrites an older pending one.
  - Else pend_v and pend_tgt hold.
- pend_tgt changes only on a capture or on reset.
- Target arithmetic: targets are used as given. The unit does no offset addition or sign extension; upstream produces absolute word addresses.

## Timing
- Latency: a redirect or increment decided in cycle N is visible on pc in cycle N+1.
- redirect is asserted in the same cycle that pc shows the new target, and is never high for two cycles from a single request.
- Stall handling:
  - Stall held for k cycles makes pc constant for k cycles.
  - The first cycle with stall=0 then performs one update: a live take, else the pending target, else +1.
  - A redirect captured during stall therefore reaches pc exactly one cycle after stall deasserts.
- Simultaneous events:
  - stall=1 together with a take: the request is captured and pc does not move.
  - stall=0 with a take and pend_v=1: the live target wins and pending clears in the same edge.
- pc_plus1 follows pc with zero cycles of latency and no register.

## Test plan
1. Reset and sequential run: WIDTH=32, RESET_PC=0x0000_0040. Hold rst 2 cycles, then release. Expect pc=0x40, 0x41, 0x42 on successive cycles and redirect=0 throughout.
2. Priority: at pc=0x10, assert br_take (0x100), jr_take (0x200) and jmp_take (0x300) in the same cycle. Next cycle expect pc=0x100 and redirect=1. The cycle after, expect pc=0x101 and redirect=0.
3. Redirect under stall: with stall=1, pulse jmp_take (target 0x80) for 1 cycle. Expect pc to hold and pending=1. Then pulse br_take (target 0x90) while stall stays high; expect pend_tgt replaced. Release stall. Next cycle expect pc=0x90, redirect=1 and pending=0.
4. Live request beats pending: set pending=1 with target 0x50. Deassert stall in the same cycle as jr_take with target 0x60. Expect pc=0x60 and pending=0; 0x50 never appears.
5. Wrap-around: WIDTH=8, RESET_PC=0xFE. Expect pc=0xFE, 0xFF, 0x00 and pc_plus1=0xFF, 0x00, 0x01.
6. Reset mid-operation: with pending=1 and stall=1, assert rst for 1 cycle. Expect pc=RESET_PC, pending=0 and redirect=0. After release, pc increments from RESET_PC and the old target never appears.
